// File: rtl/microwave_pkg.sv
// Shared types for the microwave controller: FSM state encoding and the
// BCD digit / entry-register geometry.
package microwave_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned ENTRY_W    = DIGIT_W * NUM_DIGITS;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef logic [ENTRY_W-1:0] entry_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      LOAD  = 3'd2,
      COOK  = 3'd3,
      PAUSE = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Only decimal keys are accepted; A-F codes from the keypad are dropped.
   function automatic logic is_digit(input digit_t d);
      return d <= digit_t'(9);
   endfunction

endpackage

// File: rtl/microwave_controller_if.sv
// Keypad/front-panel inputs and counter-chain handshake of the microwave
// controller, bundled so the controller and its driver share one port.
interface microwave_controller_if;
   import microwave_pkg::*;

   logic   key_valid;
   digit_t key_data;
   logic   start;
   logic   stop_clear;
   logic   door_closed;
   logic   sec_tick;
   logic   zero;

   logic   load;
   entry_t load_data;
   logic   count_en;
   logic   magnetron_on;
   logic   done;

   modport master (
      output key_valid, key_data, start, stop_clear, door_closed, sec_tick, zero,
      input  load, load_data, count_en, magnetron_on, done
   );

   modport slave (
      input  key_valid, key_data, start, stop_clear, door_closed, sec_tick, zero,
      output load, load_data, count_en, magnetron_on, done
   );

endinterface

// File: rtl/microwave_controller_bcd_entry_reg.sv
// Four-digit BCD entry register: new digits enter at sec_ones and the
// oldest digit falls off the top.
module bcd_entry_reg
   import microwave_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   shift,
   input  logic   clear,
   input  digit_t digit,
   output entry_t value
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (shift) begin
         value <= {value[ENTRY_W-DIGIT_W-1:0], digit};
      end
   end

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven controller: keypad time entry, cook/pause sequencing and a
// done indicator held for DONE_TICKS seconds, driving an external BCD counter.
module microwave_controller
   import microwave_pkg::*;
#(
   parameter int unsigned DONE_TICKS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   microwave_controller_if.slave bus
);

   localparam int unsigned TICK_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   entry_t            entry;
   logic              key_ok;
   logic              start_ok;
   logic              done_expire;
   logic              entry_shift;
   logic              entry_clear;

   assign key_ok      = bus.key_valid && is_digit(bus.key_data);
   assign start_ok    = bus.start && bus.door_closed && (entry != '0);
   assign done_expire = bus.sec_tick && (tick_cnt == TICK_W'(DONE_TICKS - 1));

   // Entry-register controls mirror the FSM priorities below so the register
   // never shifts in a cycle where a higher-priority event wins.
   always_comb begin
      entry_shift = 1'b0;
      entry_clear = 1'b0;
      case (state)
         IDLE: begin
            entry_clear = bus.stop_clear;
            entry_shift = !bus.stop_clear && key_ok;
         end
         ENTRY: begin
            entry_clear = bus.stop_clear;
            entry_shift = !bus.stop_clear && !start_ok && key_ok;
         end
         PAUSE:   entry_clear = bus.stop_clear;
         DONE:    entry_clear = bus.stop_clear || done_expire;
         default: ;
      endcase
   end

   bcd_entry_reg u_entry (
      .clk   (clk),
      .reset (reset),
      .shift (entry_shift),
      .clear (entry_clear),
      .digit (bus.key_data),
      .value (entry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.stop_clear && key_ok) state <= ENTRY;
            end
            ENTRY: begin
               if (bus.stop_clear)  state <= IDLE;
               else if (start_ok)   state <= LOAD;
            end
            LOAD: state <= COOK;
            COOK: begin
               // zero outranks an open door, so finishing wins over pausing
               if (bus.stop_clear) begin
                  state <= PAUSE;
               end else if (bus.zero) begin
                  state    <= DONE;
                  tick_cnt <= '0;
               end else if (!bus.door_closed) begin
                  state <= PAUSE;
               end
            end
            PAUSE: begin
               if (bus.stop_clear)                     state <= IDLE;
               else if (bus.start && bus.door_closed)  state <= COOK;
            end
            DONE: begin
               if (bus.stop_clear || done_expire) begin
                  state    <= IDLE;
                  tick_cnt <= '0;
               end else if (bus.sec_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.load         = (state == LOAD);
   assign bus.load_data    = (state == LOAD) ? entry : '0;
   assign bus.magnetron_on = (state == COOK);
   assign bus.count_en     = (state == COOK) && bus.sec_tick;
   assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench for microwave_controller: expected load words are queued
// when start is issued and matched against every observed load pulse.
module tb_microwave_controller;
   import microwave_pkg::*;

   logic   clk = 1'b0;
   logic   reset;
   int     tests = 0;
   int     fails = 0;
   entry_t exp_q[$];
   entry_t exp_v;

   microwave_controller_if bus ();

   microwave_controller #(.DONE_TICKS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard: every load pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.load === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL load_unexpected: load_data=%h, required no load", bus.load_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (bus.load_data !== exp_v) begin
               fails++;
               $display("FAIL load_data: got %h, required %h", bus.load_data, exp_v);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input digit_t d);
      bus.key_valid = 1'b1;
      bus.key_data  = d;
      cycle();
      bus.key_valid = 1'b0;
      bus.key_data  = '0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop_clear = 1'b1;
      cycle();
      bus.stop_clear = 1'b0;
   endtask

   task automatic go_idle();
      pulse_stop();
      pulse_stop();
   endtask

   // Enter four digits, start, and end one cycle later in COOK.
   task automatic cook_value(input entry_t v);
      for (int i = 3; i >= 0; i--) press(v[i*4 +: 4]);
      bus.door_closed = 1'b1;
      exp_q.push_back(v);
      pulse_start();
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.key_valid = 1'b0; bus.key_data = '0; bus.start = 1'b0;
      bus.stop_clear = 1'b0; bus.door_closed = 1'b1; bus.sec_tick = 1'b1;
      bus.zero = 1'b0;
      cycle(2);
      tests++;
      if ({bus.load, bus.count_en, bus.magnetron_on, bus.done} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_outputs: load/count_en/mag/done=%b, required 0000",
                  {bus.load, bus.count_en, bus.magnetron_on, bus.done});
      end
      tests++;
      if (bus.load_data !== 16'h0000) begin
         fails++;
         $display("FAIL reset_load_data: got %h, required 0000", bus.load_data);
      end
      bus.sec_tick = 1'b0;
      reset = 1'b1;
      cycle();
      tests++;
      if ({bus.load, bus.magnetron_on, bus.done} !== 3'b000) begin
         fails++;
         $display("FAIL post_reset_idle: load/mag/done=%b, required 000",
                  {bus.load, bus.magnetron_on, bus.done});
      end
   endtask

   task automatic test_load_130();
      press(4'd1); press(4'd3); press(4'd0);
      bus.door_closed = 1'b1;
      exp_q.push_back(16'h0130);
      pulse_start();
      tests++;
      if (bus.load !== 1'b1) begin
         fails++;
         $display("FAIL load_pulse: load=%b, required 1", bus.load);
      end
      cycle();
      tests++;
      if (bus.load !== 1'b0 || bus.magnetron_on !== 1'b1) begin
         fails++;
         $display("FAIL cook_entered: load=%b mag=%b, required load=0 mag=1",
                  bus.load, bus.magnetron_on);
      end
      go_idle();
   endtask

   task automatic test_shift();
      for (int d = 1; d <= 5; d++) press(digit_t'(d));
      press(4'hA);
      exp_q.push_back(16'h2345);
      pulse_start();
      cycle();
      go_idle();
      press(4'hF);
      press(4'd9); press(4'd9); press(4'd8); press(4'd7);
      exp_q.push_back(16'h9987);
      pulse_start();
      cycle();
      tests++;
      if (bus.magnetron_on !== 1'b1) begin
         fails++;
         $display("FAIL unranged_digits_cook: mag=%b, required 1", bus.magnetron_on);
      end
      go_idle();
   endtask

   task automatic test_count_en();
      cook_value(16'h0010);
      bus.sec_tick = 1'b1;
      #1;
      tests++;
      if (bus.count_en !== 1'b1) begin
         fails++;
         $display("FAIL count_en_follow_hi: got %b, required 1", bus.count_en);
      end
      bus.sec_tick = 1'b0;
      #1;
      tests++;
      if (bus.count_en !== 1'b0) begin
         fails++;
         $display("FAIL count_en_follow_lo: got %b, required 0", bus.count_en);
      end
      cycle();
      go_idle();
   endtask

   task automatic test_pause();
      cook_value(16'h0130);
      bus.door_closed = 1'b0;
      cycle();
      tests++;
      if (bus.magnetron_on !== 1'b0) begin
         fails++;
         $display("FAIL door_pause: mag=%b, required 0", bus.magnetron_on);
      end
      bus.sec_tick = 1'b1;
      #1;
      tests++;
      if (bus.count_en !== 1'b0) begin
         fails++;
         $display("FAIL pause_count_en: got %b, required 0", bus.count_en);
      end
      bus.sec_tick = 1'b0;
      cycle();
      pulse_start();
      tests++;
      if (bus.magnetron_on !== 1'b0) begin
         fails++;
         $display("FAIL start_door_open: mag=%b, required 0", bus.magnetron_on);
      end
      bus.door_closed = 1'b1;
      pulse_start();
      tests++;
      if (bus.magnetron_on !== 1'b1) begin
         fails++;
         $display("FAIL resume_cook: mag=%b, required 1", bus.magnetron_on);
      end
      pulse_stop();
      tests++;
      if (bus.magnetron_on !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL stop_pause: mag=%b done=%b, required 0 0", bus.magnetron_on, bus.done);
      end
      pulse_stop();
      pulse_start();
      tests++;
      if (bus.load !== 1'b0) begin
         fails++;
         $display("FAIL idle_start: load=%b, required 0", bus.load);
      end
      press(4'd5);
      exp_q.push_back(16'h0005);
      pulse_start();
      cycle();
      go_idle();
   endtask

   task automatic test_done();
      press(4'd5);
      bus.door_closed = 1'b1;
      exp_q.push_back(16'h0005);
      pulse_start();
      bus.zero = 1'b1;
      cycle();
      tests++;
      if (bus.magnetron_on !== 1'b1 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL zero_in_load: mag=%b done=%b, required 1 0", bus.magnetron_on, bus.done);
      end
      bus.door_closed = 1'b0;
      cycle();
      tests++;
      if (bus.done !== 1'b1 || bus.magnetron_on !== 1'b0) begin
         fails++;
         $display("FAIL zero_beats_door: done=%b mag=%b, required 1 0", bus.done, bus.magnetron_on);
      end
      bus.zero = 1'b0;
      bus.door_closed = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         bus.sec_tick = 1'b1;
         #1;
         tests++;
         if (bus.count_en !== 1'b0) begin
            fails++;
            $display("FAIL done_count_en: tick %0d got %b, required 0", t, bus.count_en);
         end
         cycle();
         bus.sec_tick = 1'b0;
         tests++;
         if (bus.done !== (t < 3)) begin
            fails++;
            $display("FAIL done_hold: after tick %0d done=%b, required %b", t, bus.done, (t < 3));
         end
         cycle();
      end
      press(4'd7);
      exp_q.push_back(16'h0007);
      pulse_start();
      cycle();
      go_idle();
   endtask

   task automatic test_done_stop();
      cook_value(16'h0002);
      bus.zero = 1'b1;
      cycle();
      bus.zero = 1'b0;
      bus.sec_tick = 1'b1;
      cycle();
      bus.sec_tick = 1'b0;
      pulse_stop();
      tests++;
      if (bus.done !== 1'b0) begin
         fails++;
         $display("FAIL done_stop: done=%b, required 0", bus.done);
      end
   endtask

   task automatic test_start_reject();
      bus.door_closed = 1'b1;
      pulse_start();
      press(4'd0);
      pulse_start();
      tests++;
      if (bus.load !== 1'b0) begin
         fails++;
         $display("FAIL start_entry_zero: load=%b, required 0", bus.load);
      end
      press(4'd2);
      bus.door_closed = 1'b0;
      pulse_start();
      tests++;
      if (bus.load !== 1'b0 || bus.magnetron_on !== 1'b0) begin
         fails++;
         $display("FAIL start_door_open_entry: load=%b mag=%b, required 0 0",
                  bus.load, bus.magnetron_on);
      end
      bus.door_closed = 1'b1;
      pulse_stop();
      press(4'd6);
      exp_q.push_back(16'h0006);
      pulse_start();
      cycle();
      go_idle();
   endtask

   task automatic test_stop_zero();
      cook_value(16'h0042);
      bus.stop_clear = 1'b1;
      bus.zero = 1'b1;
      cycle();
      bus.stop_clear = 1'b0;
      bus.zero = 1'b0;
      tests++;
      if (bus.magnetron_on !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL stop_over_zero: mag=%b done=%b, required 0 0", bus.magnetron_on, bus.done);
      end
      pulse_start();
      bus.sec_tick = 1'b1;
      #1;
      tests++;
      if (bus.magnetron_on !== 1'b1 || bus.count_en !== 1'b1) begin
         fails++;
         $display("FAIL pause_resume: mag=%b count_en=%b, required 1 1",
                  bus.magnetron_on, bus.count_en);
      end
      #1;
      reset = 1'b0;
      #1;
      tests++;
      if ({bus.load, bus.count_en, bus.magnetron_on, bus.done} !== 4'b0000) begin
         fails++;
         $display("FAIL async_reset_cook: load/count_en/mag/done=%b, required 0000",
                  {bus.load, bus.count_en, bus.magnetron_on, bus.done});
      end
      cycle();
      bus.sec_tick = 1'b0;
      reset = 1'b1;
      cycle();
   endtask

   task automatic test_back_to_back();
      cook_value(16'h1234);
      bus.zero = 1'b1;
      cycle();
      bus.zero = 1'b0;
      pulse_stop();
      cook_value(16'h0056);
      tests++;
      if (bus.magnetron_on !== 1'b1) begin
         fails++;
         $display("FAIL back_to_back_cook: mag=%b, required 1", bus.magnetron_on);
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_load_130();
      test_shift();
      test_count_en();
      test_pause();
      test_done();
      test_done_stop();
      test_start_reject();
      test_stop_zero();
      test_back_to_back();
      cycle(2);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_loads: %0d expected loads never seen, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
